// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-4 stream demultiplexer:
// channel count, select width, channel index type and slot state encoding.
package demux_pkg;

    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_idx_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic [CH_NUM-1:0] sel_onehot(input ch_idx_t idx);
        sel_onehot      = '0;
        sel_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output holding slot with a valid/ready handshake towards its consumer.
// can_load tells the upstream decode whether a beat may be written this cycle.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              can_load
);

    slot_state_t state_q, state_d;
    logic [DATA_W-1:0] data_q;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (load) state_d = SLOT_FULL;
            SLOT_FULL:  if (dout_ready && !load) state_d = SLOT_EMPTY;
        endcase
    end

    // NOTE: the data register is reset on purpose: outputs must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= din;
        end
    end

    assign dout       = data_q;
    assign dout_valid = (state_q == SLOT_FULL);
    assign can_load   = !dout_valid || dout_ready;

endmodule

// File: rtl/demux_1x4_buf.sv
// Registered 1-to-4 stream demultiplexer: {s1,s0} routes each input beat into one of
// four independent output slots. Define DEMUX_CNT_EN to add per-channel beat counters.
module demux_1x4_buf
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              s1,
    input  logic              s0,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] o0,
    output logic [DATA_W-1:0] o1,
    output logic [DATA_W-1:0] o2,
    output logic [DATA_W-1:0] o3,
    output logic              o0_valid,
    output logic              o1_valid,
    output logic              o2_valid,
    output logic              o3_valid,
    input  logic              o0_ready,
    input  logic              o1_ready,
    input  logic              o2_ready,
    input  logic              o3_ready
`ifdef DEMUX_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3
`endif
);

    ch_idx_t             sel;
    logic                accept;
    logic [CH_NUM-1:0]   load_vec;
    logic [CH_NUM-1:0]   slot_can_load;
    logic [CH_NUM-1:0]   slot_valid;
    logic [CH_NUM-1:0]   slot_ready;
    logic [DATA_W-1:0]   slot_data [CH_NUM];

    assign sel        = {s1, s0};
    assign slot_ready = {o3_ready, o2_ready, o1_ready, o0_ready};

    // Ready-through: the selected slot may accept if empty or draining this cycle.
    assign din_ready = slot_can_load[sel];
    assign accept    = din_valid && din_ready;
    assign load_vec  = accept ? sel_onehot(sel) : '0;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_slot
        demux_out_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load_vec[g]),
            .din       (din),
            .dout      (slot_data[g]),
            .dout_valid(slot_valid[g]),
            .dout_ready(slot_ready[g]),
            .can_load  (slot_can_load[g])
        );
    end

    assign o0       = slot_data[0];
    assign o1       = slot_data[1];
    assign o2       = slot_data[2];
    assign o3       = slot_data[3];
    assign o0_valid = slot_valid[0];
    assign o1_valid = slot_valid[1];
    assign o2_valid = slot_valid[2];
    assign o3_valid = slot_valid[3];

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q [CH_NUM];

    // Saturating accept counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_NUM; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (cnt_clr) begin
                    cnt_q[i] <= '0;
                end else if (load_vec[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_1x4_buf.sv
// Scoreboard bench for demux_1x4_buf: expected beats are queued per channel on accept
// and popped when the channel drains. Counter checks are active with DEMUX_CNT_EN.
module tb_demux_1x4_buf;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] din;
    logic              s1, s0;
    logic              din_valid;
    logic              din_ready;
    logic [DATA_W-1:0] o0, o1, o2, o3;
    logic              o0_valid, o1_valid, o2_valid, o3_valid;
    logic [3:0]        ordy;
    logic [DATA_W-1:0] ov [4];
    logic [3:0]        ovld;
`ifdef DEMUX_CNT_EN
    logic              cnt_clr;
    logic [CNT_W-1:0]  cnt0, cnt1, cnt2, cnt3;
    logic [CNT_W-1:0]  cv [4];
    logic [CNT_W-1:0]  mcnt [4];
`endif

    int checks = 0;
    int errors = 0;

    // Bench-side model of slot occupancy and last loaded data.
    logic              mvalid [4];
    logic [DATA_W-1:0] mlast  [4];
    logic [DATA_W-1:0] sb     [4][$];

    always #5 clk = ~clk;

    demux_1x4_buf #(
        .DATA_W(DATA_W)
`ifdef DEMUX_CNT_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .s1       (s1),
        .s0       (s0),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .o0       (o0),
        .o1       (o1),
        .o2       (o2),
        .o3       (o3),
        .o0_valid (o0_valid),
        .o1_valid (o1_valid),
        .o2_valid (o2_valid),
        .o3_valid (o3_valid),
        .o0_ready (ordy[0]),
        .o1_ready (ordy[1]),
        .o2_ready (ordy[2]),
        .o3_ready (ordy[3])
`ifdef DEMUX_CNT_EN
        ,
        .cnt_clr  (cnt_clr),
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .cnt2     (cnt2),
        .cnt3     (cnt3)
`endif
    );

    assign ov[0] = o0;
    assign ov[1] = o1;
    assign ov[2] = o2;
    assign ov[3] = o3;
    assign ovld  = {o3_valid, o2_valid, o1_valid, o0_valid};
`ifdef DEMUX_CNT_EN
    assign cv[0] = cnt0;
    assign cv[1] = cnt1;
    assign cv[2] = cnt2;
    assign cv[3] = cnt3;
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 4; ch++) begin
            mvalid[ch] = 1'b0;
            mlast[ch]  = '0;
            sb[ch].delete();
`ifdef DEMUX_CNT_EN
            mcnt[ch] = '0;
`endif
        end
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_din_ready"}, {31'b0, din_ready}, 32'd1);
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("%s_o%0d_valid", tag, ch), {31'b0, ovld[ch]}, 32'd0);
            check($sformatf("%s_o%0d", tag, ch), {24'b0, ov[ch]}, 32'd0);
`ifdef DEMUX_CNT_EN
            check($sformatf("%s_cnt%0d", tag, ch), {28'b0, cv[ch]}, 32'd0);
`endif
        end
    endtask

    // Drives one beat (or idle), checks at the falling edge, advances the model to the next rising edge.
    task automatic cycle(input logic v, input logic [1:0] sel, input logic [DATA_W-1:0] d,
                         input logic clr);
        logic             exp_rdy;
        logic             acc;
        logic [DATA_W-1:0] exp_d;
        din_valid = v;
        {s1, s0}  = sel;
        din       = d;
`ifdef DEMUX_CNT_EN
        cnt_clr   = clr;
`endif
        @(negedge clk);
        exp_rdy = !mvalid[sel] || ordy[sel];
        check($sformatf("din_ready_ch%0d", sel), {31'b0, din_ready}, {31'b0, exp_rdy});
        acc = v && exp_rdy;
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("o%0d_valid", ch), {31'b0, ovld[ch]}, {31'b0, mvalid[ch]});
            check($sformatf("o%0d_hold", ch), {24'b0, ov[ch]}, {24'b0, mlast[ch]});
`ifdef DEMUX_CNT_EN
            check($sformatf("cnt%0d", ch), {28'b0, cv[ch]}, {28'b0, mcnt[ch]});
`endif
            if (mvalid[ch] && ordy[ch]) begin
                if (sb[ch].size() == 0) begin
                    check($sformatf("sb%0d_underflow", ch), 32'd1, 32'd0);
                end else begin
                    exp_d = sb[ch].pop_front();
                    check($sformatf("o%0d_drain", ch), {24'b0, ov[ch]}, {24'b0, exp_d});
                end
            end
            if (acc && (sel == ch[1:0])) begin
                mvalid[ch] = 1'b1;
                mlast[ch]  = d;
                sb[ch].push_back(d);
            end else if (mvalid[ch] && ordy[ch]) begin
                mvalid[ch] = 1'b0;
            end
`ifdef DEMUX_CNT_EN
            if (clr) mcnt[ch] = '0;
            else if (acc && (sel == ch[1:0]) && (mcnt[ch] != '1)) mcnt[ch] = mcnt[ch] + 1'b1;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        {s1, s0}  = 2'b00;
        din_valid = 1'b1;
        ordy      = 4'hF;
`ifdef DEMUX_CNT_EN
        cnt_clr   = 1'b0;
`endif
        model_reset();

        // Accepts are ignored while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check_all_reset("in_reset");
        rst_n = 1'b1;

        // Single beat to channel 2.
        cycle(1'b1, 2'b10, 8'hA5, 1'b0);
        cycle(1'b0, 2'b00, 8'h00, 1'b0);
        check("o2_a5", {24'b0, o2}, 32'h0000_00A5);

        // Back-to-back stream to channel 3.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 2'b11, 8'(i), 1'b0);
        cycle(1'b0, 2'b00, 8'h00, 1'b0);
        check("o3_last", {24'b0, o3}, 32'h0000_0008);

        // Backpressure on channel 1, then drain and refill in one cycle.
        ordy[1] = 1'b0;
        cycle(1'b1, 2'b01, 8'h11, 1'b0);
        cycle(1'b1, 2'b01, 8'h22, 1'b0);
        cycle(1'b1, 2'b01, 8'h22, 1'b0);
        ordy[1] = 1'b1;
        cycle(1'b1, 2'b01, 8'h22, 1'b0);
        cycle(1'b0, 2'b00, 8'h00, 1'b0);
        check("o1_refill", {24'b0, o1}, 32'h0000_0022);

        // Stalled channel 0 must not block channel 2.
        ordy[0] = 1'b0;
        cycle(1'b1, 2'b00, 8'h44, 1'b0);
        cycle(1'b1, 2'b10, 8'h33, 1'b0);
        cycle(1'b0, 2'b00, 8'h00, 1'b0);
        check("o2_33", {24'b0, o2}, 32'h0000_0033);
        check("o0_untouched", {24'b0, o0}, 32'h0000_0044);

        // Fill every slot, then reset asynchronously mid-cycle.
        ordy = 4'h0;
        cycle(1'b1, 2'b01, 8'h55, 1'b0);
        cycle(1'b1, 2'b10, 8'h66, 1'b0);
        cycle(1'b1, 2'b11, 8'h77, 1'b0);
        cycle(1'b0, 2'b00, 8'h00, 1'b0);
        check("all_full", {28'b0, ovld}, 32'h0000_000F);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_reset("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ordy  = 4'hF;

`ifdef DEMUX_CNT_EN
        // Counter saturation and clear-over-increment priority.
        for (int i = 0; i < 17; i++) cycle(1'b1, 2'b01, 8'(8'h80 + i), 1'b0);
        cycle(1'b0, 2'b00, 8'h00, 1'b0);
        check("cnt1_sat", {28'b0, cnt1}, 32'd15);
        cycle(1'b1, 2'b01, 8'hAA, 1'b1);
        cycle(1'b0, 2'b00, 8'h00, 1'b0);
        check("cnt1_clr", {28'b0, cnt1}, 32'd0);
`endif

        // Mixed traffic with random consumer stalls.
        for (int i = 0; i < 60; i++) begin
            ordy = 4'($urandom);
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 1'b0);
        end
        ordy = 4'hF;
        repeat (3) cycle(1'b0, 2'b00, 8'h00, 1'b0);
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("sb%0d_empty", ch), sb[ch].size(), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
